// File: rtl/sa_isa_pkg.sv
// Shared ISA definitions for the systolic array front end and controller.
// Contents: opcode constants, instruction field ranges, the issue FSM
// state type and a small opcode classification helper.
package sa_isa_pkg;

    // Opcodes, carried in instruction bits [4:0]
    localparam logic [4:0] OP_NOP       = 5'b00000;
    localparam logic [4:0] OP_COMPUTE   = 5'b00001;
    localparam logic [4:0] OP_COMPUTE_I = 5'b00010;
    localparam logic [4:0] OP_ACC_TO_OB = 5'b00011;
    localparam logic [4:0] OP_LD_INP    = 5'b00100;
    localparam logic [4:0] OP_LD_WT     = 5'b00101;
    localparam logic [4:0] OP_OB_SEND   = 5'b00110;
    localparam logic [4:0] OP_ACC_RST   = 5'b00111;
    localparam logic [4:0] OP_HALT      = 5'b11111;

    // Instruction field ranges
    localparam int OPC_LSB  = 0;
    localparam int OPC_MSB  = 4;
    localparam int ADDR_LSB = 5;
    localparam int ADDR_MSB = 20;
    localparam int DATA_LSB = 21;
    localparam int DATA_MSB = 52;

    // Issue FSM states
    typedef enum logic [1:0] {
        ST_ISSUE = 2'b00,
        ST_WAIT  = 2'b01,
        ST_HALT  = 2'b10
    } iq_state_t;

    // Both compute flavours stall the issue stream for the array latency
    function automatic logic is_compute(input logic [4:0] opc);
        return (opc == OP_COMPUTE) || (opc == OP_COMPUTE_I);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with power-of-two depth.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push, wr_data     write request and data (ignored when full)
//   pop, rd_data      read request (ignored when empty); rd_data is the
//                     current head word, valid whenever empty is 0
//   full, empty       occupancy flags
//   count             current occupancy, 0..DEPTH
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_s;
    logic             pop_s;

    // Requests are qualified here so a caller can never over/underflow
    assign push_s  = push && (count_r != CNT_FULL);
    assign pop_s   = pop && (count_r != {CW{1'b0}});
    assign full    = (count_r == CNT_FULL);
    assign empty   = (count_r == {CW{1'b0}});
    assign count   = count_r;
    assign rd_data = mem_r[rd_ptr_r];

    // Storage array; contents are not reset, only the pointers are
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks push/pop balance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/instr_issue_queue.sv
// Instruction issue queue: buffers host instructions and issues one per
// cycle (registered) to the controller decode stage. Inserts NOPs after
// compute instructions and stops issuing after a halt until resumed.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   host_instr, host_valid  host write channel
//   host_ready              queue not full (combinational)
//   instruction             registered issued word (0 = NOP)
//   issue_valid             instruction holds a real popped word
//   halted                  queue is in HALT
//   resume                  one-cycle pulse releasing HALT
//   fifo_count              current FIFO occupancy
module instr_issue_queue
    import sa_isa_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int INSTR_W     = 64,
    parameter int COMPUTE_LAT = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [INSTR_W-1:0]     host_instr,
    input  logic                   host_valid,
    output logic                   host_ready,
    output logic [INSTR_W-1:0]     instruction,
    output logic                   issue_valid,
    output logic                   halted,
    input  logic                   resume,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam logic [7:0] LAT_C = 8'(COMPUTE_LAT);

    iq_state_t          state_r;
    iq_state_t          state_nx_s;
    logic [7:0]         wait_cnt_r;
    logic [7:0]         wait_cnt_nx_s;
    logic [INSTR_W-1:0] instr_nx_s;
    logic               valid_nx_s;
    logic               pop_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic [INSTR_W-1:0] fifo_head_s;
    logic [4:0]         head_opc_s;

    assign host_ready = !fifo_full_s;
    assign head_opc_s = fifo_head_s[OPC_MSB:OPC_LSB];

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (host_valid),
        .wr_data (host_instr),
        .pop     (pop_s),
        .rd_data (fifo_head_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count)
    );

    // Next-state, pop request and next output word for the issue FSM
    always_comb begin
        state_nx_s    = state_r;
        wait_cnt_nx_s = wait_cnt_r;
        instr_nx_s    = {INSTR_W{1'b0}};
        valid_nx_s    = 1'b0;
        pop_s         = 1'b0;
        case (state_r)
            ST_ISSUE: begin
                if (!fifo_empty_s) begin
                    pop_s      = 1'b1;
                    instr_nx_s = fifo_head_s;
                    valid_nx_s = 1'b1;
                    if (is_compute(head_opc_s)) begin
                        // A zero latency means no stall at all
                        if (LAT_C != 8'd0) begin
                            state_nx_s    = ST_WAIT;
                            wait_cnt_nx_s = LAT_C;
                        end else begin
                            state_nx_s = ST_ISSUE;
                        end
                    end else if (head_opc_s == OP_HALT) begin
                        state_nx_s = ST_HALT;
                    end else begin
                        state_nx_s = ST_ISSUE;
                    end
                end else begin
                    state_nx_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                // Leaving on the 1->0 step yields exactly COMPUTE_LAT NOPs
                if (wait_cnt_r > 8'd1) begin
                    wait_cnt_nx_s = wait_cnt_r - 8'd1;
                end else begin
                    wait_cnt_nx_s = 8'd0;
                    state_nx_s    = ST_ISSUE;
                end
            end
            ST_HALT: begin
                if (resume) begin
                    state_nx_s = ST_ISSUE;
                end else begin
                    state_nx_s = ST_HALT;
                end
            end
            default: begin
                state_nx_s    = ST_ISSUE;
                wait_cnt_nx_s = 8'd0;
            end
        endcase
    end

    // FSM state, wait counter and registered issue outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_ISSUE;
            wait_cnt_r  <= 8'd0;
            instruction <= {INSTR_W{1'b0}};
            issue_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            wait_cnt_r  <= wait_cnt_nx_s;
            instruction <= instr_nx_s;
            issue_valid <= valid_nx_s;
            halted      <= (state_nx_s == ST_HALT);
        end
    end

endmodule
